// File: rtl/sll_iter.sv
// Iterative logical shift-left: one bit position per clock, start/ready handshake in,
// one-cycle done pulse out with a registered result.
module sll_iter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] out
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   logic [N-1:0]   acc;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  amt;
   logic [N-1:0]   acc_shl;

   // Any amount of N or more clears every bit, so cap the iteration count at N.
   function automatic logic [CW-1:0] sat_amt(input logic [N-1:0] s);
      if (s >= N'(N))
         return CW'(N);
      return s[CW-1:0];
   endfunction

   assign amt     = sat_amt(b);
   assign acc_shl = {acc[N-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         out   <= '0;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= a;
                  cnt   <= amt;
                  ready <= 1'b0;
                  if (amt == '0) begin
                     out   <= a;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc <= acc_shl;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  out   <= acc_shl;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
